// File: rtl/char_glyph_writer.sv
// Host byte stream to per-bit glyph write strobes: header + two data bytes fill one 4x3 glyph,
// and the twelve bit writes are paced by the blanking signal.
`timescale 1ns/1ps
module char_glyph_writer #(
   parameter int NUM_CHARS = 16,
   parameter int IDX_W     = 4
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             blank,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_glyph,
   output logic [1:0]       wr_x,
   output logic [2:0]       wr_y,
   output logic             wr_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [2:0]       fsm_state
);
   // Handshake: a byte transfers on a rising edge where in_valid & in_ready; the source holds the byte otherwise.
   typedef enum logic [2:0] {
      S_WAIT_HDR = 3'd0,
      S_WAIT_D0  = 3'd1,
      S_WAIT_D1  = 3'd2,
      S_WRITE    = 3'd3,
      S_FINISH   = 3'd4
   } state_t;

   localparam logic [7:0] NUM_CHARS_B = 8'(NUM_CHARS);

   state_t           state, state_d;
   logic [3:0]       k, k_d;
   logic [11:0]      glyph, glyph_d;
   logic [IDX_W-1:0] idx, idx_d;
   logic             wr_en_d, wr_data_d, done_d, err_d;
   logic [IDX_W-1:0] wr_glyph_d;
   logic [1:0]       wr_x_d;
   logic [2:0]       wr_y_d;
   logic             accept, is_hdr, hdr_ok, do_write;

   assign in_ready  = !rst && (state == S_WAIT_HDR || state == S_WAIT_D0 || state == S_WAIT_D1);
   assign busy      = (state != S_WAIT_HDR);
   assign fsm_state = state;
   assign accept    = in_valid && in_ready;
   assign is_hdr    = in_data[7];
   assign hdr_ok    = ({1'b0, in_data[6:0]} < NUM_CHARS_B);

   always_comb begin
      state_d    = state;
      k_d        = k;
      glyph_d    = glyph;
      idx_d      = idx;
      wr_en_d    = 1'b0;
      wr_glyph_d = wr_glyph;
      wr_x_d     = wr_x;
      wr_y_d     = wr_y;
      wr_data_d  = wr_data;
      done_d     = 1'b0;
      err_d      = 1'b0;
      do_write   = 1'b0;
      case (state)
         S_WAIT_HDR: begin
            if (accept) begin
               if (is_hdr && hdr_ok) begin
                  idx_d   = in_data[IDX_W-1:0];
                  state_d = S_WAIT_D0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_WAIT_D0, S_WAIT_D1: begin
            if (accept) begin
               if (is_hdr) begin
                  err_d = 1'b1;
                  if (hdr_ok) begin
                     idx_d   = in_data[IDX_W-1:0];
                     state_d = S_WAIT_D0;
                  end else begin
                     state_d = S_WAIT_HDR;
                  end
               end else if (state == S_WAIT_D0) begin
                  glyph_d[5:0] = in_data[5:0];
                  state_d      = S_WAIT_D1;
               end else begin
                  // Bit 0 comes from D0, so the first write can go out on the D1 edge itself.
                  glyph_d[11:6] = in_data[5:0];
                  k_d           = 4'd0;
                  state_d       = S_WRITE;
                  do_write      = blank;
               end
            end
         end
         S_WRITE:  do_write = blank;
         S_FINISH: begin
            done_d  = 1'b1;
            state_d = S_WAIT_HDR;
         end
         default:  state_d = S_WAIT_HDR;
      endcase
      if (do_write) begin
         wr_en_d    = 1'b1;
         wr_glyph_d = idx_d;
         wr_x_d     = 2'(k % 4'd3);
         wr_y_d     = 3'(k / 4'd3);
         wr_data_d  = glyph[k];
         if (k == 4'd11) begin
            k_d     = 4'd0;
            state_d = S_FINISH;
         end else begin
            k_d = k + 4'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state    <= S_WAIT_HDR;
         k        <= '0;
         glyph    <= '0;
         idx      <= '0;
         wr_en    <= 1'b0;
         wr_glyph <= '0;
         wr_x     <= '0;
         wr_y     <= '0;
         wr_data  <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_d;
         k        <= k_d;
         glyph    <= glyph_d;
         idx      <= idx_d;
         wr_en    <= wr_en_d;
         wr_glyph <= wr_glyph_d;
         wr_x     <= wr_x_d;
         wr_y     <= wr_y_d;
         wr_data  <= wr_data_d;
         done     <= done_d;
         err      <= err_d;
      end
   end
endmodule

// File: tb/tb_char_glyph_writer.sv
// Bench for char_glyph_writer: a frame-level queue model checked every cycle, plus literal
// expectations for each directed scenario.
`timescale 1ns/1ps
module tb_char_glyph_writer;
   localparam int NUM_CHARS = 16;
   localparam int IDX_W     = 4;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       blank = 1'b0;
   logic       in_ready, wr_en, wr_data, busy, done, err;
   logic [3:0] wr_glyph;
   logic [1:0] wr_x;
   logic [2:0] wr_y;
   logic [2:0] fsm_state;

   always #5 clock = ~clock;

   char_glyph_writer #(.NUM_CHARS(NUM_CHARS), .IDX_W(IDX_W)) dut (
      .clock(clock), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .blank(blank), .wr_en(wr_en), .wr_glyph(wr_glyph), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .busy(busy), .done(done), .err(err), .fsm_state(fsm_state)
   );

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] x;
      logic [2:0] y;
      logic       d;
   } wrec_t;

   // Model: phase 0 header, 1 D0, 2 D1, 3 writing, 4 last write showing
   wrec_t      wq[$];
   int         phase = 0;
   logic [5:0] m_d0 = '0;
   logic [3:0] m_idx = '0;
   logic       started = 1'b0;
   logic       e_wr_en = 0, e_data = 0, e_done = 0, e_err = 0;
   logic [3:0] e_glyph = '0;
   logic [1:0] e_x = '0;
   logic [2:0] e_y = '0;

   int          n_assert = 0, n_fail = 0;
   int          cap_n = 0, n_err = 0, n_done = 0, blank_mode = 0;
   logic [31:0] cap_bits = '0;
   logic [3:0]  cap_glyph = '0;
   logic [1:0]  cap_x = '0;
   logic [2:0]  cap_y = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_pop();
      wrec_t r;
      r = wq.pop_front();
      e_wr_en = 1'b1;
      e_glyph = r.g;
      e_x     = r.x;
      e_y     = r.y;
      e_data  = r.d;
      if (wq.size() == 0) phase = 4;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [11:0] bits;
      if (b[7]) begin
         if (phase != 0) e_err = 1'b1;
         if (b[6:0] < NUM_CHARS) begin
            m_idx = b[3:0];
            phase = 1;
         end else begin
            e_err = 1'b1;
            phase = 0;
         end
      end else if (phase == 0) begin
         e_err = 1'b1;
      end else if (phase == 1) begin
         m_d0  = b[5:0];
         phase = 2;
      end else begin
         bits = {b[5:0], m_d0};
         for (int i = 0; i < 12; i++)
            wq.push_back('{g: m_idx, x: 2'(i % 3), y: 3'(i / 3), d: bits[i]});
         phase = 3;
         if (blank) model_pop();
      end
   endtask

   always @(posedge clock) begin
      started = 1'b1;
      if (rst) begin
         phase = 0;
         wq.delete();
         e_wr_en = 0; e_glyph = 0; e_x = 0; e_y = 0; e_data = 0; e_err = 0; e_done = 0;
      end else begin
         e_wr_en = 0;
         e_err   = 0;
         e_done  = 0;
         if (phase == 4) begin
            e_done = 1'b1;
            phase  = 0;
         end else if (phase == 3) begin
            if (blank) model_pop();
         end else if (in_valid) begin
            model_byte(in_data);
         end
      end
   end

   always @(negedge clock) begin
      if (started) begin
         check("wr_en", 32'(wr_en), 32'(e_wr_en));
         check("wr_glyph", 32'(wr_glyph), 32'(e_glyph));
         check("wr_x", 32'(wr_x), 32'(e_x));
         check("wr_y", 32'(wr_y), 32'(e_y));
         check("wr_data", 32'(wr_data), 32'(e_data));
         check("done", 32'(done), 32'(e_done));
         check("err", 32'(err), 32'(e_err));
         check("busy", 32'(busy), 32'(phase != 0));
         check("in_ready", 32'(in_ready), 32'(!rst && phase < 3));
         if (wr_en) begin
            if (cap_n < 32) cap_bits[cap_n] = wr_data;
            cap_glyph = wr_glyph;
            cap_x     = wr_x;
            cap_y     = wr_y;
            cap_n++;
         end
         if (done) n_done++;
         if (err) n_err++;
      end
   end

   initial begin
      int ph = 0;
      forever begin
         @(posedge clock);
         #2;
         case (blank_mode)
            0: blank = 1'b1;
            1: begin
               blank = (ph < 3);
               ph = (ph + 1) % 8;
            end
            default: blank = 1'b0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic clear_cap();
      cap_n = 0; n_err = 0; n_done = 0; cap_bits = '0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  t  = 0;
      logic hs = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      while (!hs) begin
         @(negedge clock);
         hs = in_ready;
         tick();
         t++;
         if (!hs && t > 500) begin
            n_assert++;
            n_fail++;
            $display("FAIL send_byte_timeout: byte %0h never accepted", b);
            hs = 1'b1;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] h, input logic [7:0] d0, input logic [7:0] d1);
      send_byte(h);
      send_byte(d0);
      send_byte(d1);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int t = 0;
      while (n_done < target && t < 400) begin
         tick();
         t++;
      end
      check("wait_done_bound", 32'(n_done >= target), 32'd1);
      tick();
      tick();
   endtask

   initial begin
      int cnt;
      rst = 1'b1;
      repeat (3) @(posedge clock);
      #2 rst = 1'b0;
      @(negedge clock);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_wr_en", 32'(wr_en), 32'd0);
      tick();

      // Frame with blank held high
      blank_mode = 0;
      clear_cap();
      send_frame(8'h83, 8'h2A, 8'h15);
      wait_done(1);
      check("t1_count", 32'(cap_n), 32'd12);
      check("t1_bits", cap_bits, 32'h56A);
      check("t1_glyph", 32'(cap_glyph), 32'd3);
      check("t1_last_xy", {cap_x, cap_y}, {2'd2, 3'd3});
      check("t1_err", 32'(n_err), 32'd0);
      check("t1_done", 32'(n_done), 32'd1);

      // Same frame, blank 3 high / 5 low
      blank_mode = 1;
      clear_cap();
      send_frame(8'h83, 8'h2A, 8'h15);
      wait_done(1);
      check("t2_count", 32'(cap_n), 32'd12);
      check("t2_bits", cap_bits, 32'h56A);
      check("t2_done", 32'(n_done), 32'd1);

      // Out-of-range header then stray data, then a good frame
      blank_mode = 0;
      clear_cap();
      send_byte(8'h90);
      send_byte(8'h05);
      in_valid = 1'b0;
      repeat (3) tick();
      check("t3_err", 32'(n_err), 32'd2);
      check("t3_no_write", 32'(cap_n), 32'd0);
      check("t3_busy", 32'(busy), 32'd0);
      send_frame(8'h85, 8'h3F, 8'h00);
      wait_done(1);
      check("t3_bits", cap_bits, 32'h03F);
      check("t3_glyph", 32'(cap_glyph), 32'd5);

      // Resync on a header mid-frame
      clear_cap();
      send_byte(8'h81);
      send_byte(8'h3F);
      send_byte(8'h82);
      send_byte(8'h00);
      send_byte(8'h3F);
      in_valid = 1'b0;
      wait_done(1);
      check("t4_err", 32'(n_err), 32'd1);
      check("t4_glyph", 32'(cap_glyph), 32'd2);
      check("t4_bits", cap_bits, 32'hFC0);
      check("t4_count", 32'(cap_n), 32'd12);

      // Reset after the fifth write
      clear_cap();
      send_frame(8'h83, 8'h2A, 8'h15);
      cnt = 0;
      for (int i = 0; i < 100 && cnt < 5; i++) begin
         @(negedge clock);
         if (wr_en) cnt++;
      end
      check("t5_reached5", 32'(cnt), 32'd5);
      #1 rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (20) tick();
      check("t5_count", 32'(cap_n), 32'd5);
      check("t5_done", 32'(n_done), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_glyph", 32'(wr_glyph), 32'd0);

      // Back-to-back frames with in_valid held
      clear_cap();
      send_byte(8'h83);
      send_byte(8'h2A);
      send_byte(8'h15);
      send_byte(8'h84);
      send_byte(8'h3F);
      send_byte(8'h00);
      in_valid = 1'b0;
      wait_done(2);
      check("t6_count", 32'(cap_n), 32'd24);
      check("t6_bits", cap_bits, 32'h0003F56A);
      check("t6_done", 32'(n_done), 32'd2);
      check("t6_err", 32'(n_err), 32'd0);
      check("t6_glyph", 32'(cap_glyph), 32'd4);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/char_glyph_writer.md
Name: char_glyph_writer

Overview:
- Write-side companion to the character glyph memories: turns a byte stream from the host (Arduino interface) into per-bit write strobes for a selected 4x3 glyph.
- Glyph bit k maps to y = k/3, x = k%3 (memory bit 3y+x).
- Writes advance only while the display is in blanking, so scanout reads never see a half-written glyph mid-line.

Parameters:
- NUM_CHARS, 16, number of glyph memories addressable; header index must be < NUM_CHARS.
- IDX_W, 4, width of wr_glyph; must satisfy 2^IDX_W >= NUM_CHARS.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  command/data byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a byte; transfer when in_valid & in_ready at a rising edge.
- blank  in  1  high during video blanking; writes advance only when high.
- wr_en  out  1  one-cycle write strobe per glyph bit.
- wr_glyph  out  IDX_W  target glyph index.
- wr_x  out  2  column 0..2 (3 never driven).
- wr_y  out  3  row 0..3 (4..7 never driven).
- wr_data  out  1  bit value.
- busy  out  1  high from header acceptance until done.
- done  out  1  one-cycle pulse after the 12th write.
- err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset: state WAIT_HDR, all outputs 0, bit counter 0, latched index/data 0. in_ready is 1 from the first cycle after rst deasserts. rst asserted mid-frame or mid-WRITE aborts immediately: no further wr_en, and bits already written stay written.
- Byte format:
  - Header: bit7=1, bits[6:0] = glyph index.
  - Data: bit7=0, bits[5:0] = payload, bit6 ignored.
  - Frame: header, D0 (glyph bits 5:0), D1 (glyph bits 11:6).
- WAIT_HDR (in_ready=1):
  - Valid header: latch index, set busy, go to WAIT_D0.
  - Header with index >= NUM_CHARS: consume, pulse err, stay.
  - Data byte: consume, pulse err, stay.
- WAIT_D0 / WAIT_D1 (in_ready=1):
  - Data byte: latch payload, advance.
  - Header byte (resync): pulse err, abandon frame. A valid header is re-latched and the block goes to WAIT_D0; an out-of-range header drops busy and returns to WAIT_HDR.
- WRITE (in_ready=0):
  - Bit counter k runs 0..11.
  - On each rising edge with blank=1: register wr_en=1, wr_x=k%3, wr_y=k/3, wr_data=glyph[k], wr_glyph=index; increment k.
  - On an edge with blank=0: register wr_en=0 and hold k. The address outputs may hold their last values.
  - With blank held high, wr_en is high for exactly the 12 cycles following the D1 handshake edge, with k ascending.
- DONE:
  - done=1 for exactly the cycle after the last wr_en cycle; busy drops in that same cycle.
  - in_ready returns to 1 in that same cycle, and a byte may be accepted then.
  - The block then returns to WAIT_HDR.
- Output timing: wr_en, done and err are never high for more than one consecutive cycle per event. The exception is wr_en, which is high on consecutive cycles during contiguous blank.
- in_valid without in_ready (during WRITE) is not consumed; the byte must be held by the source.

Test Plan:
- Frame 0x83, 0x2A, 0x15 with blank=1 -> wr_glyph=3; 12 consecutive wr_en cycles writing bits (k0..k11) = 0,1,0,1,0,1,1,0,1,0,1,0 at (x,y) (0,0),(1,0),(2,0),(0,1)...(2,3); done pulse the next cycle; no err.
- Same frame with blank toggling 3 cycles high / 5 low -> wr_en only in blank-high cycles, 12 writes total in order, done after the 12th; in_ready=0 throughout WRITE.
- Header 0x90 with NUM_CHARS=16, then data 0x05 -> two err pulses, no wr_en, busy stays 0; a following valid frame writes normally.
- Header 0x81, D0 0x3F, then header 0x82, D0 0x00, D1 0x3F -> one err pulse at the second header; wr_glyph=2; bits 0..5 =0 and 6..11 =1.
- rst asserted for 1 cycle after the 5th wr_en -> no further wr_en, done stays 0, all outputs 0; in_ready=1 the next cycle.
- Back-to-back frames with in_valid held high -> the second header is accepted in the done cycle; the second frame's writes start with no dropped bytes.
